// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared types and widths for the DDS sweep controller and phase accumulator wrapper
package dds_pkg;

   localparam int PHINC_W = 8;
   localparam int DWELL_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2,
      HOLD = 2'd3
   } sweep_state_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// rtl/dds_sweep_ctrl_if.sv - control/config/status bundle between software side (master) and sweep controller (slave)
interface dds_sweep_ctrl_if #(
   parameter int PW  = 8,
   parameter int DWW = 16
);
   logic           start;
   logic           stop;
   logic [PW-1:0]  f_start;
   logic [PW-1:0]  f_stop;
   logic [PW-1:0]  step;
   logic [DWW-1:0] dwell;
   logic [PW-1:0]  phinc;
   logic           busy;
   logic           done;

   modport master (
      output start, stop, f_start, f_stop, step, dwell,
      input  phinc, busy, done
   );

   modport slave (
      input  start, stop, f_start, f_stop, step, dwell,
      output phinc, busy, done
   );
endinterface

// File: rtl/dds_dwell_timer.sv
// rtl/dds_dwell_timer.sv - loadable dwell down-counter; expired while the count sits at zero
module dds_dwell_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] val,
   output logic         expired
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == '0);
endmodule

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - phinc frequency-sweep FSM with config latch and clamped stepping
// Optional triangle (continuous up/down) sweep enabled by defining SWEEP_TRIANGLE_EN.
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int PW  = PHINC_W,
   parameter int DWW = DWELL_W
) (
   input logic             clk,
   input logic             rst,
   dds_sweep_ctrl_if.slave sw
);
   sweep_state_t   state;
   logic [PW-1:0]  phinc_q;
   logic           busy_q;
   logic           done_q;
   logic [PW-1:0]  f_start_l;
   logic [PW-1:0]  f_stop_l;
   logic [PW-1:0]  step_l;
   logic [DWW-1:0] dwell_l;

   logic           expired;
   logic           load;
   logic [DWW-1:0] load_val;
   logic           start_go;
   logic           tick;
   logic           at_top;
   logic [PW:0]    up_sum;
   logic [PW-1:0]  up_val;
`ifdef SWEEP_TRIANGLE_EN
   logic           at_bot;
   logic [PW:0]    dn_floor;
   logic [PW-1:0]  dn_val;
`endif

   // Sums are one bit wider so the clamp sees overflow instead of a wrapped value.
   always_comb begin
      start_go = sw.start && !sw.stop && (state == IDLE || state == HOLD);
      tick     = expired && !sw.stop && (state == UP || state == DOWN);
      load     = start_go || tick;
      load_val = start_go ? sw.dwell : dwell_l;
      up_sum   = {1'b0, phinc_q} + {1'b0, step_l};
      up_val   = (up_sum > {1'b0, f_stop_l}) ? f_stop_l : up_sum[PW-1:0];
      at_top   = (phinc_q >= f_stop_l);
`ifdef SWEEP_TRIANGLE_EN
      at_bot   = (phinc_q <= f_start_l);
      dn_floor = {1'b0, f_start_l} + {1'b0, step_l};
      dn_val   = ({1'b0, phinc_q} < dn_floor) ? f_start_l : (phinc_q - step_l);
`endif
   end

   dds_dwell_timer #(.W(DWW)) u_dwell (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .val     (load_val),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         phinc_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         f_start_l <= '0;
         f_stop_l  <= '0;
         step_l    <= '0;
         dwell_l   <= '0;
      end else if (sw.stop) begin
         state  <= HOLD;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (start_go) begin
         f_start_l <= sw.f_start;
         f_stop_l  <= sw.f_stop;
         step_l    <= (sw.step == '0) ? {{(PW-1){1'b0}}, 1'b1} : sw.step;
         dwell_l   <= sw.dwell;
         phinc_q   <= sw.f_start;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
         state     <= UP;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE, HOLD: begin
               busy_q <= 1'b0;
            end
            UP: begin
               if (expired) begin
                  if (!at_top) begin
                     phinc_q <= up_val;
                  end else begin
`ifdef SWEEP_TRIANGLE_EN
                     // Degenerate range has nowhere to go: keep f_start, pulse done each period.
                     if (f_start_l >= f_stop_l) begin
                        done_q <= 1'b1;
                     end else begin
                        state   <= DOWN;
                        phinc_q <= dn_val;
                     end
`else
                     state  <= HOLD;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
`endif
                  end
               end
            end
`ifdef SWEEP_TRIANGLE_EN
            DOWN: begin
               if (expired) begin
                  if (!at_bot) begin
                     phinc_q <= dn_val;
                  end else begin
                     state   <= UP;
                     phinc_q <= up_val;
                     done_q  <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state  <= HOLD;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign sw.phinc = phinc_q;
   assign sw.busy  = busy_q;
   assign sw.done  = done_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - directed self-checking bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   dds_sweep_ctrl_if #(.PW(8), .DWW(16)) sw ();

   dds_sweep_ctrl #(.PW(8), .DWW(16)) dut (
      .clk (clk),
      .rst (rst),
      .sw  (sw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [7:0] ph, input logic bz, input logic dn);
      chk({tag, ".phinc"}, 32'(sw.phinc), 32'(ph));
      chk({tag, ".busy"},  32'(sw.busy),  32'(bz));
      chk({tag, ".done"},  32'(sw.done),  32'(dn));
   endtask

   task automatic launch(input logic [7:0] fs, input logic [7:0] fe, input logic [7:0] st, input logic [15:0] dw);
      sw.f_start = fs;
      sw.f_stop  = fe;
      sw.step    = st;
      sw.dwell   = dw;
      sw.start   = 1'b1;
      @(negedge clk);
      sw.start   = 1'b0;
   endtask

   initial begin
      logic [7:0] seq1 [9];
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      sw.start = 1'b0;
      sw.stop  = 1'b0;
      sw.f_start = '0;
      sw.f_stop  = '0;
      sw.step    = '0;
      sw.dwell   = '0;
      seq1 = '{8'd10, 8'd10, 8'd10, 8'd15, 8'd15, 8'd15, 8'd20, 8'd20, 8'd20};

      repeat (2) @(negedge clk);
      chk_out("reset", 8'd0, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk_out("idle", 8'd0, 1'b0, 1'b0);

      // basic up-sweep; config inputs changed after start must not matter
      launch(8'd10, 8'd20, 8'd5, 16'd2);
      sw.f_start = 8'd99;
      sw.f_stop  = 8'd100;
      sw.step    = 8'd1;
      sw.dwell   = 16'd7;
      for (int i = 0; i < 9; i++) begin
         chk_out($sformatf("t1.s%0d", i), seq1[i], 1'b1, 1'b0);
         @(negedge clk);
      end
      chk_out("t1.done", 8'd20, 1'b0, 1'b1);
      @(negedge clk);
      chk_out("t1.after", 8'd20, 1'b0, 1'b0);

      // clamp near the top of the range
      launch(8'd250, 8'd255, 8'd4, 16'd0);
      chk_out("t2.s0", 8'd250, 1'b1, 1'b0);
      @(negedge clk);
      chk_out("t2.s1", 8'd254, 1'b1, 1'b0);
      @(negedge clk);
      chk_out("t2.s2", 8'd255, 1'b1, 1'b0);
      @(negedge clk);
      chk_out("t2.done", 8'd255, 1'b0, 1'b1);
      @(negedge clk);

      // stop mid-sweep, then start+stop together
      launch(8'd10, 8'd20, 8'd5, 16'd2);
      repeat (3) @(negedge clk);
      chk_out("t3.at15", 8'd15, 1'b1, 1'b0);
      sw.stop = 1'b1;
      @(negedge clk);
      sw.stop = 1'b0;
      chk_out("t3.stop", 8'd15, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      chk_out("t3.hold", 8'd15, 1'b0, 1'b0);
      sw.start = 1'b1;
      sw.stop  = 1'b1;
      @(negedge clk);
      sw.start = 1'b0;
      sw.stop  = 1'b0;
      chk_out("t3.both", 8'd15, 1'b0, 1'b0);
      @(negedge clk);
      chk_out("t3.both2", 8'd15, 1'b0, 1'b0);

      // step=0 acts as 1
      launch(8'd0, 8'd3, 8'd0, 16'd0);
      for (int i = 0; i < 4; i++) begin
         chk_out($sformatf("t4.s%0d", i), 8'(i), 1'b1, 1'b0);
         @(negedge clk);
      end
      chk_out("t4.done", 8'd3, 1'b0, 1'b1);
      @(negedge clk);

      // equal and inverted ranges
      launch(8'd7, 8'd7, 8'd3, 16'd0);
      chk_out("t4.eq.s0", 8'd7, 1'b1, 1'b0);
      @(negedge clk);
      chk_out("t4.eq.done", 8'd7, 1'b0, 1'b1);
      @(negedge clk);
      launch(8'd9, 8'd4, 8'd2, 16'd1);
      chk_out("t4.inv.s0", 8'd9, 1'b1, 1'b0);
      @(negedge clk);
      chk_out("t4.inv.s1", 8'd9, 1'b1, 1'b0);
      @(negedge clk);
      chk_out("t4.inv.done", 8'd9, 1'b0, 1'b1);
      @(negedge clk);

      // start while busy is ignored, then async reset mid-sweep
      launch(8'd10, 8'd20, 8'd5, 16'd2);
      @(negedge clk);
      sw.f_start = 8'd40;
      sw.dwell   = 16'd0;
      sw.start   = 1'b1;
      @(negedge clk);
      sw.start   = 1'b0;
      chk_out("t5.s2", 8'd10, 1'b1, 1'b0);
      @(negedge clk);
      chk_out("t5.s3", 8'd15, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_out("t5.rst", 8'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_out("t5.idle", 8'd0, 1'b0, 1'b0);
      launch(8'd33, 8'd40, 8'd1, 16'd0);
      chk_out("t5.restart", 8'd33, 1'b1, 1'b0);
      sw.stop = 1'b1;
      @(negedge clk);
      sw.stop = 1'b0;

`ifdef SWEEP_TRIANGLE_EN
      launch(8'd0, 8'd8, 8'd4, 16'd0);
      chk_out("t6.s0", 8'd0, 1'b1, 1'b0);
      @(negedge clk);
      chk_out("t6.s1", 8'd4, 1'b1, 1'b0);
      @(negedge clk);
      chk_out("t6.s2", 8'd8, 1'b1, 1'b0);
      @(negedge clk);
      chk_out("t6.s3", 8'd4, 1'b1, 1'b0);
      @(negedge clk);
      chk_out("t6.s4", 8'd0, 1'b1, 1'b0);
      @(negedge clk);
      chk_out("t6.s5", 8'd4, 1'b1, 1'b1);
      @(negedge clk);
      chk_out("t6.s6", 8'd8, 1'b1, 1'b0);
      sw.stop = 1'b1;
      @(negedge clk);
      sw.stop = 1'b0;
      chk_out("t6.stop", 8'd8, 1'b0, 1'b0);
      @(negedge clk);
      chk_out("t6.hold", 8'd8, 1'b0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
